// File: rtl/sram_row_sequencer.sv
// sram_row_sequencer: moves a burst of consecutive SRAM rows between the
// SRAM master port and a pair of streams. Writes go from s_* into the SRAM,
// one row per cycle. Reads go out on m_*, with one SRAM read outstanding at a
// time, so a read row takes at least three cycles.
//
// Handshake semantics (applies to s_*, m_* and the rq_* request channel):
// a beat transfers on the rising edge where valid and ready are both high.
// Once valid is raised by this block, it and its data stay stable until the
// beat. rd_valid_i is a one-cycle response pulse with no ready.
module sram_row_sequencer #(
    parameter  int numRows  = 128,
    parameter  int numCols  = 32,
    localparam int addrBits = $clog2(numRows),
    localparam int cntBits  = addrBits + 1
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                start_i,
    input  logic                dir_i,
    input  logic [addrBits-1:0] base_addr_i,
    input  logic [cntBits-1:0]  num_rows_i,
    output logic                busy_o,
    output logic                done_o,
    output logic [cntBits-1:0]  rows_done_o,
    input  logic [numCols-1:0]  s_data_i,
    input  logic                s_valid_i,
    output logic                s_ready_o,
    output logic [numCols-1:0]  m_data_o,
    output logic                m_valid_o,
    input  logic                m_ready_i,
    output logic                rq_wr_o,
    output logic                rq_valid_o,
    output logic [numCols-1:0]  wr_data_o,
    output logic [addrBits-1:0] addr_o,
    input  logic                rq_ready_i,
    input  logic                rd_valid_i,
    input  logic [numCols-1:0]  rd_data_i,
    output logic [2:0]          dbg_state_o
);

    typedef enum logic [2:0] {
        S_IDLE    = 3'd0,
        S_WRITE   = 3'd1,
        S_RD_REQ  = 3'd2,
        S_RD_WAIT = 3'd3,
        S_RD_OUT  = 3'd4,
        S_DONE    = 3'd5
    } state_t;

    localparam logic [cntBits-1:0]  ONE_ROW  = cntBits'(1);
    localparam logic [addrBits-1:0] LAST_ROW = addrBits'(numRows - 1);

    state_t                r_state;
    logic [addrBits-1:0]   r_addr;
    logic [cntBits-1:0]    r_remaining;
    logic [cntBits-1:0]    r_rows_done;
    logic                  r_m_valid;
    logic [numCols-1:0]    r_m_data;

    logic [addrBits-1:0]   w_addr_next;
    logic                  w_wr_beat;

    // Row after the current one, wrapping at the top of the bank even when
    // numRows is not a power of two.
    always_comb begin
        w_addr_next = r_addr + addrBits'(1);
        if (r_addr == LAST_ROW) begin
            w_addr_next = '0;
        end
    end

    assign w_wr_beat = (r_state == S_WRITE) && s_valid_i && rq_ready_i;

    // Burst sequencing: latch the burst on start, then walk rows until done.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state     <= S_IDLE;
            r_addr      <= '0;
            r_remaining <= '0;
            r_rows_done <= '0;
            r_m_valid   <= 1'b0;
            r_m_data    <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (start_i) begin
                        r_addr      <= base_addr_i;
                        r_remaining <= num_rows_i;
                        r_rows_done <= '0;
                        if (num_rows_i == '0) begin
                            r_state <= S_DONE;
                        end else if (dir_i) begin
                            r_state <= S_WRITE;
                        end else begin
                            r_state <= S_RD_REQ;
                        end
                    end
                end
                S_WRITE: begin
                    if (w_wr_beat) begin
                        r_addr      <= w_addr_next;
                        r_remaining <= r_remaining - ONE_ROW;
                        r_rows_done <= r_rows_done + ONE_ROW;
                        if (r_remaining == ONE_ROW) begin
                            r_state <= S_DONE;
                        end
                    end
                end
                S_RD_REQ: begin
                    if (rq_ready_i) begin
                        r_state <= S_RD_WAIT;
                    end
                end
                S_RD_WAIT: begin
                    // Responses are only accepted here, so a stale response
                    // after reset or outside a read is dropped.
                    if (rd_valid_i) begin
                        r_m_data  <= rd_data_i;
                        r_m_valid <= 1'b1;
                        r_state   <= S_RD_OUT;
                    end
                end
                S_RD_OUT: begin
                    if (m_ready_i) begin
                        r_m_valid   <= 1'b0;
                        r_addr      <= w_addr_next;
                        r_remaining <= r_remaining - ONE_ROW;
                        r_rows_done <= r_rows_done + ONE_ROW;
                        if (r_remaining > ONE_ROW) begin
                            r_state <= S_RD_REQ;
                        end else begin
                            r_state <= S_DONE;
                        end
                    end
                end
                S_DONE: begin
                    r_state <= S_IDLE;
                end
                default: begin
                    r_state <= S_IDLE;
                end
            endcase
        end
    end

    // Status decoded from the state register only.
    assign busy_o      = (r_state != S_IDLE);
    assign done_o      = (r_state == S_DONE);
    assign rows_done_o = r_rows_done;
    assign dbg_state_o = r_state;

    // Read stream is fully registered.
    assign m_valid_o = r_m_valid;
    assign m_data_o  = r_m_data;

    // Write path is a zero-latency pass-through of the s_* stream onto the
    // SRAM request channel; reads issue a request from RD_REQ.
    assign rq_valid_o = ((r_state == S_WRITE) && s_valid_i) || (r_state == S_RD_REQ);
    assign rq_wr_o    = (r_state == S_WRITE);
    assign wr_data_o  = (r_state == S_WRITE) ? s_data_i : '0;
    assign addr_o     = r_addr;
    assign s_ready_o  = (r_state == S_WRITE) && rq_ready_i;

endmodule

// File: doc/sram_row_sequencer.md
SRAM_ROW_SEQUENCER -- requirements
Module: sram_row_sequencer

Interface
REQ-001 SHALL have parameter numRows, default 128, meaning SRAM rows per bank.
REQ-002 SHALL have parameter numCols, default 32, meaning bits per SRAM row.
REQ-003 SHALL use addrBits = $clog2(numRows) for all row-address widths; cntBits = addrBits+1.
REQ-004 SHALL have: clk  in  1  sole clock, all logic on rising edge.
REQ-005 SHALL have: rst  in  1  synchronous, active-high reset.
REQ-006 SHALL have: start_i  in  1  burst start, sampled only in IDLE.
REQ-007 SHALL have: dir_i  in  1  burst direction, 1 = write to SRAM, 0 = read from SRAM; sampled with start_i.
REQ-008 SHALL have: base_addr_i  in  addrBits  first row of the burst; sampled with start_i.
REQ-009 SHALL have: num_rows_i  in  cntBits  rows in the burst; sampled with start_i.
REQ-010 SHALL have: busy_o  out  1  high in any state except IDLE.
REQ-011 SHALL have: done_o  out  1  one-cycle pulse at burst completion.
REQ-012 SHALL have: rows_done_o  out  cntBits  rows completed in the current or last burst.
REQ-013 SHALL have: s_data_i / s_valid_i / s_ready_o  in/in/out  numCols/1/1  write-data stream into SRAM.
REQ-014 SHALL have: m_data_o / m_valid_o / m_ready_i  out/out/in  numCols/1/1  read-data stream out of SRAM.
REQ-015 SHALL have SRAM master side: rq_wr_o out 1, rq_valid_o out 1, wr_data_o out numCols, addr_o out addrBits, rq_ready_i in 1, rd_valid_i in 1, rd_data_i in numCols. These match the sram_itf master modport semantics.

Function
REQ-016 SHALL implement the states IDLE, WRITE, RD_REQ, RD_WAIT, RD_OUT and DONE.
REQ-017 In IDLE, start_i=1 SHALL latch base_addr_i into addr, num_rows_i into remaining, and clear rows_done_o. The next state SHALL be WRITE if dir_i=1, otherwise RD_REQ.
REQ-018 start_i=1 with num_rows_i=0 SHALL go directly to DONE; no SRAM request is issued.
REQ-019 start_i SHALL be ignored in every state other than IDLE.
REQ-020 In WRITE, the block SHALL drive rq_valid_o=s_valid_i, rq_wr_o=1, wr_data_o=s_data_i, addr_o=addr and s_ready_o=rq_ready_i. This path is combinational pass-through with zero added latency.
REQ-021 A write beat SHALL occur when s_valid_i=1 and rq_ready_i=1 in the same cycle. On each beat: addr increments, remaining decrements, rows_done_o increments.
REQ-022 The beat that brings remaining to 0 SHALL move the FSM to DONE on the next cycle.
REQ-023 In RD_REQ, the block SHALL drive rq_valid_o=1, rq_wr_o=0 and addr_o=addr. On rq_ready_i=1 it SHALL move to RD_WAIT.
REQ-024 In RD_WAIT, rd_valid_i=1 SHALL register rd_data_i into m_data_o and set m_valid_o=1 on the next cycle, and the FSM SHALL move to RD_OUT. At most one read is outstanding at any time.
REQ-025 In RD_OUT, m_valid_o=1 and m_data_o SHALL hold stable until m_ready_i=1. On that beat: addr increments, remaining decrements, rows_done_o increments. The next state SHALL be RD_REQ if remaining>1, otherwise DONE.
REQ-026 Address arithmetic SHALL wrap modulo numRows (row numRows-1 is followed by row 0).
REQ-027 rd_valid_i SHALL be ignored outside RD_WAIT.
REQ-028 DONE SHALL last exactly one cycle with done_o=1, then return to IDLE; rows_done_o SHALL hold until the next start.
REQ-029 Outside their active state, the following SHALL be 0: rq_valid_o, s_ready_o, m_valid_o and rq_wr_o.
REQ-030 Minimum read-burst throughput SHALL be one row per 3 cycles when the SRAM and sink respond immediately. Write throughput SHALL be one row per cycle.

Reset
REQ-031 rst=1 SHALL force IDLE on the next edge, from any state including mid-burst.
REQ-032 rst=1 SHALL force to 0: busy_o, done_o, rows_done_o, m_valid_o, m_data_o, rq_valid_o, rq_wr_o, s_ready_o, addr and remaining.
REQ-033 A read response that arrives after a mid-burst reset SHALL be discarded.

Verification
REQ-034 Write burst: base=5, num=4, s_valid_i held 1, rq_ready_i=1 -> addr_o 5,6,7,8 on 4 consecutive cycles; done_o pulses 1 cycle later; rows_done_o=4.
REQ-035 Wrap: write, base=126, num=4 (numRows=128) -> addr_o 126,127,0,1.
REQ-036 Read with backpressure: base=0, num=2, rd_valid_i 2 cycles after accept, m_ready_i low for 3 cycles -> m_data_o stable while stalled; second RD_REQ only after the first m_valid_o/m_ready_i beat; done_o after the second beat.
REQ-037 Zero length: num=0, start_i=1 -> busy_o high 1 cycle, done_o=1, no rq_valid_o ever asserted, rows_done_o=0.
REQ-038 Mid-burst reset: rst=1 in RD_WAIT, then rd_valid_i=1 -> m_valid_o stays 0, FSM in IDLE, all outputs 0.
REQ-039 Busy start: start_i pulsed during WRITE with different base -> ignored; the original burst completes unchanged.
